// File: rtl/serial_sub_ctrl.sv
// -----------------------------------------------------------------------------
// serial_sub_ctrl
//
// Bit-serial sequencer for one external single-bit full-subtractor cell
// (A, B, Bi -> Df, Bo). It latches two WIDTH-bit operands and a borrow-in on
// an accepted start. It then feeds the cell one bit pair per clock, LSB first,
// and returns each borrow-out to the cell as the next borrow-in. The difference
// is assembled one bit at a time and presented with a one-cycle done pulse.
// One cell therefore does a WIDTH-bit subtraction without a ripple chain.
//
// Parameters:
//   WIDTH    operand/result width in bits (2..64)
//
// Optional feature:
//   SERIAL_SUB_ABORT_EN  when defined, adds an 'abort' input. Abort in RUN
//                        returns to IDLE with no done pulse and clears
//                        diff/bout. Start wins over abort in IDLE.
//
// Ports:
//   clk        in   1      clock, rising edge
//   rst_n      in   1      asynchronous reset, active low
//   start      in   1      request, sampled only in IDLE
//   abort      in   1      (SERIAL_SUB_ABORT_EN only) abandon a RUN sequence
//   a          in   WIDTH  minuend, sampled with start
//   b          in   WIDTH  subtrahend, sampled with start
//   bin        in   1      initial borrow-in, sampled with start
//   busy       out  1      high in RUN and DONE
//   done       out  1      one-cycle pulse, diff/bout valid
//   diff       out  WIDTH  a - b - bin mod 2^WIDTH, held until next start
//   bout       out  1      final borrow-out (1 = underflow)
//   cell_a     out  1      to cell A
//   cell_b     out  1      to cell B
//   cell_bi    out  1      to cell Bi
//   cell_df    in   1      from cell Df
//   cell_bo    in   1      from cell Bo
// -----------------------------------------------------------------------------
module serial_sub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SERIAL_SUB_ABORT_EN
  input  logic             abort,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             cell_a,
  output logic             cell_b,
  output logic             cell_bi,
  input  logic             cell_df,
  input  logic             cell_bo
);

  localparam int CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shA_q, shA_d;
  logic [WIDTH-1:0] shB_q, shB_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             brw_q, brw_d;
  logic             bout_q, bout_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             abortReq;

`ifdef SERIAL_SUB_ABORT_EN
  assign abortReq = abort;
`else
  assign abortReq = 1'b0;
`endif

  // State, operand shifters, running borrow, bit counter and result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      shA_q   <= '0;
      shB_q   <= '0;
      diff_q  <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shA_q   <= shA_d;
      shB_q   <= shB_d;
      diff_q  <= diff_d;
      brw_q   <= brw_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and outputs. The cell inputs come from registers only, so
  // start has no combinational path to any output.
  always_comb begin
    state_d = state_q;
    shA_d   = shA_q;
    shB_d   = shB_q;
    diff_d  = diff_q;
    brw_d   = brw_q;
    bout_d  = bout_q;
    cnt_d   = cnt_q;
    busy    = 1'b0;
    done    = 1'b0;
    cell_a  = 1'b0;
    cell_b  = 1'b0;
    cell_bi = 1'b0;

    case (state_q)
      StIdle: begin
        // diff/bout keep the previous result until the first bit lands.
        if (start) begin
          state_d = StRun;
          shA_d   = a;
          shB_d   = b;
          brw_d   = bin;
          cnt_d   = '0;
        end
      end

      StRun: begin
        busy    = 1'b1;
        cell_a  = shA_q[0];
        cell_b  = shB_q[0];
        cell_bi = brw_q;
        if (abortReq) begin
          state_d = StIdle;
          diff_d  = '0;
          bout_d  = 1'b0;
        end else begin
          // Each difference bit enters at the MSB; after WIDTH shifts the
          // first (LSB) bit has reached position 0.
          diff_d = {cell_df, diff_q[WIDTH-1:1]};
          brw_d  = cell_bo;
          shA_d  = shA_q >> 1;
          shB_d  = shB_q >> 1;
          if (cnt_q == LastCnt) begin
            bout_d  = cell_bo;
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      StDone: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_sub_ctrl
//
// Self-checking bench for serial_sub_ctrl. The external full-subtractor cell
// is modelled with continuous assigns. Expected results come from hand-worked
// vectors and from an arithmetic reference model (plain integer subtraction).
// Inputs are driven and outputs sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_serial_sub_ctrl;

  localparam int W = 8;
  typedef logic [W-1:0] word_t;

  typedef struct {
    string tag;
    word_t a;
    word_t b;
    logic  bin;
    word_t expDiff;
    logic  expBout;
  } vec_t;

  logic  clk;
  logic  rstN;
  logic  startIn;
  word_t aIn;
  word_t bIn;
  logic  binIn;
  logic  busy;
  logic  done;
  word_t diff;
  logic  bout;
  logic  cellA;
  logic  cellB;
  logic  cellBi;
  logic  cellDf;
  logic  cellBo;
`ifdef SERIAL_SUB_ABORT_EN
  logic  abortIn;
`endif

  int    checks;
  int    errors;
  word_t modelDiff;
  logic  modelBout;

  serial_sub_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rstN),
    .start   (startIn),
`ifdef SERIAL_SUB_ABORT_EN
    .abort   (abortIn),
`endif
    .a       (aIn),
    .b       (bIn),
    .bin     (binIn),
    .busy    (busy),
    .done    (done),
    .diff    (diff),
    .bout    (bout),
    .cell_a  (cellA),
    .cell_b  (cellB),
    .cell_bi (cellBi),
    .cell_df (cellDf),
    .cell_bo (cellBo)
  );

  // One-bit full subtractor: borrow out whenever A < B + Bi.
  assign cellDf = cellA ^ cellB ^ cellBi;
  assign cellBo = (~cellA & (cellB | cellBi)) | (cellB & cellBi);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W:0] refSub(input word_t x, input word_t y, input logic bi);
    int r;
    r = int'(x) - int'(y) - int'(bi);
    return {r < 0, r[W-1:0]};
  endfunction

  // Borrow entering bit k is the borrow out of the k low-order bits.
  function automatic logic refBorrowIn(input word_t x, input word_t y, input logic bi, input int k);
    int m;
    m = (1 << k) - 1;
    return (int'(x) & m) < ((int'(y) & m) + int'(bi));
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic s, input word_t av, input word_t bv, input logic bi);
    @(negedge clk);
    startIn = s;
    aIn     = av;
    bIn     = bv;
    binIn   = bi;
  endtask

  task automatic checkIdleZero(input string name);
    checkOutput({name, ".busy"}, 64'(busy), 64'(0));
    checkOutput({name, ".done"}, 64'(done), 64'(0));
    checkOutput({name, ".cells"}, 64'({cellA, cellB, cellBi}), 64'(0));
  endtask

  // One full operation from an IDLE falling edge, checking per-bit cell
  // feeding, done latency/width and result holding.
  task automatic runOp(input string tag, input word_t av, input word_t bv, input logic bi,
                       input word_t expDiff, input logic expBout);
    int cyc;
    applyStimulus(1'b1, av, bv, bi);
    // Scramble the inputs after acceptance; only the latched copies count.
    applyStimulus(1'b0, word_t'($urandom), word_t'($urandom), 1'($urandom));
    checkOutput({tag, ".holdDiff"}, 64'(diff), 64'(modelDiff));
    checkOutput({tag, ".holdBout"}, 64'(bout), 64'(modelBout));
    cyc = 1;
    while (done !== 1'b1 && cyc <= 3 * W) begin
      if (cyc <= W) begin
        checkOutput({tag, ".busyRun"}, 64'(busy), 64'(1));
        checkOutput({tag, ".cellA"}, 64'(cellA), 64'(av[cyc-1]));
        checkOutput({tag, ".cellB"}, 64'(cellB), 64'(bv[cyc-1]));
        checkOutput({tag, ".cellBi"}, 64'(cellBi), 64'(refBorrowIn(av, bv, bi, cyc - 1)));
      end
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, ".latency"}, 64'(cyc), 64'(W + 1));
    checkOutput({tag, ".diff"}, 64'(diff), 64'(expDiff));
    checkOutput({tag, ".bout"}, 64'(bout), 64'(expBout));
    checkOutput({tag, ".busyDone"}, 64'(busy), 64'(1));
    checkOutput({tag, ".cellsDone"}, 64'({cellA, cellB, cellBi}), 64'(0));
    @(negedge clk);
    checkIdleZero({tag, ".after"});
    checkOutput({tag, ".diffHeld"}, 64'(diff), 64'(expDiff));
    checkOutput({tag, ".boutHeld"}, 64'(bout), 64'(expBout));
    modelDiff = expDiff;
    modelBout = expBout;
  endtask

  initial begin
    vec_t       vecs[8];
    logic [W:0] r;
    word_t      ra;
    word_t      rb;
    logic       rbi;
    int         cyc;

    vecs[0] = '{"v5A_23", 8'h5A, 8'h23, 1'b0, 8'h37, 1'b0};
    vecs[1] = '{"v00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
    vecs[2] = '{"v10_0F", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0};
    vecs[3] = '{"vFF_01", 8'hFF, 8'h01, 1'b0, 8'hFE, 1'b0};
    vecs[4] = '{"v00_00", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
    vecs[5] = '{"vFF_FF", 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0};
    vecs[6] = '{"v80_7F", 8'h80, 8'h7F, 1'b1, 8'h00, 1'b0};
    vecs[7] = '{"v01_FF", 8'h01, 8'hFF, 1'b1, 8'h01, 1'b1};

    checks    = 0;
    errors    = 0;
    modelDiff = '0;
    modelBout = 1'b0;
    rstN      = 1'b0;
    startIn   = 1'b0;
    aIn       = '0;
    bIn       = '0;
    binIn     = 1'b0;
`ifdef SERIAL_SUB_ABORT_EN
    abortIn   = 1'b0;
`endif

    // Reset state.
    #2;
    checkIdleZero("reset");
    checkOutput("reset.diff", 64'(diff), 64'(0));
    checkOutput("reset.bout", 64'(bout), 64'(0));
    @(negedge clk);
    rstN = 1'b1;

    // Hand-worked vectors.
    foreach (vecs[i]) begin
      runOp(vecs[i].tag, vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].expDiff, vecs[i].expBout);
    end

    // Start pulses while busy are ignored, not queued.
    applyStimulus(1'b1, 8'h5A, 8'h23, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    applyStimulus(1'b1, 8'h00, 8'hFF, 1'b1);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    cyc = 4;
    while (done !== 1'b1 && cyc <= 3 * W) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("ignore.latency", 64'(cyc), 64'(W + 1));
    checkOutput("ignore.diff", 64'(diff), 64'(8'h37));
    checkOutput("ignore.bout", 64'(bout), 64'(0));
    startIn = 1'b1;
    aIn     = 8'h00;
    bIn     = 8'hFF;
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    checkIdleZero("ignore.busyDrop");
    @(negedge clk);
    checkIdleZero("ignore.notQueued");
    checkOutput("ignore.diffHeld", 64'(diff), 64'(8'h37));
    modelDiff = 8'h37;
    modelBout = 1'b0;

    // Start held high: back-to-back operations, done every W+2 cycles.
    applyStimulus(1'b1, 8'h5A, 8'h23, 1'b0);
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      checkOutput("held.done", 64'(done), 64'(i % (W + 2) == W + 1));
      if (i % (W + 2) == 0) begin
        checkOutput("held.idleBusy", 64'(busy), 64'(0));
        checkOutput("held.idleCells", 64'({cellA, cellB, cellBi}), 64'(0));
      end
      if (i % (W + 2) == W + 1) begin
        checkOutput("held.diff", 64'(diff), 64'(8'h37));
      end
    end
    startIn = 1'b0;
    modelDiff = 8'h37;
    modelBout = 1'b0;

    // Reset in the middle of RUN abandons the operation.
    applyStimulus(1'b1, 8'hC3, 8'h15, 1'b1);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    checkOutput("midReset.busyBefore", 64'(busy), 64'(1));
    rstN = 1'b0;
    #1;
    checkIdleZero("midReset");
    checkOutput("midReset.diff", 64'(diff), 64'(0));
    checkOutput("midReset.bout", 64'(bout), 64'(0));
    @(negedge clk);
    checkIdleZero("midReset.hold");
    rstN = 1'b1;
    modelDiff = '0;
    modelBout = 1'b0;
    runOp("afterReset", 8'hFF, 8'h01, 1'b0, 8'hFE, 1'b0);

`ifdef SERIAL_SUB_ABORT_EN
    // Abort mid-RUN: no done, result cleared, next op completes normally.
    runOp("preAbort", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
    applyStimulus(1'b1, 8'h5A, 8'h23, 1'b0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    abortIn = 1'b1;
    @(negedge clk);
    abortIn = 1'b0;
    checkIdleZero("abort");
    checkOutput("abort.diff", 64'(diff), 64'(0));
    checkOutput("abort.bout", 64'(bout), 64'(0));
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      checkOutput("abort.noDone", 64'(done), 64'(0));
    end
    modelDiff = '0;
    modelBout = 1'b0;
    runOp("postAbort", 8'h5A, 8'h23, 1'b0, 8'h37, 1'b0);
`endif

    // Random operations against the arithmetic reference.
    for (int n = 0; n < 40; n++) begin
      ra  = word_t'($urandom);
      rb  = word_t'($urandom);
      rbi = 1'($urandom);
      if (n == 0) begin
        ra = '0;
        rb = '1;
      end
      r = refSub(ra, rb, rbi);
      runOp("rand", ra, rb, rbi, r[W-1:0], r[W]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
